exception_unit: RTL
===================

Name: exception_unit

Overview:
- Consumer side of the decoder's exception signalling (Exc, EStatus, ERet) in the LEGv8 pipelined core.
- Holds the exception state registers ELR, ESR and ECNT, and sequences the pipeline flush, vectoring and ERET return.
- Gates the external interrupt request forwarded to the main decoder.
- Sits beside the decode stage; its outputs drive the fetch PC mux and the pipeline flush lines.

Parameters:
N, 64, datapath and PC width.
VECTOR, 64'h00000000000000D8, exception handler entry address.
FLUSH_CYCLES, 3, cycles Flush is held after an exception is accepted (range 1-15).
CNT_W, 16, width of the saturating exception counter ECNT.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
Exc_D  in  1  exception flag from the main decoder.
EStatus_D  in  4  cause from the main decoder: 0001 = external IRQ, 0010 = invalid opcode.
ERet_D  in  1  ERET decoded.
PC_D  in  N  PC of the instruction in decode.
ExtIRQ_in  in  1  device interrupt request; level, held until acknowledged.
IrqAck  out  1  one-cycle acknowledge to the device.
ExtIRQ_dec  out  1  gated IRQ to the main decoder.
Flush  out  1  flush IF/ID/EX.
VecTaken  out  1  fetch selects VECTOR this cycle.
RetTaken  out  1  fetch selects RetPC this cycle.
RetPC  out  N  equals ELR.
MrsSel  in  2  MRS source select: 00 ELR, 01 ESR, 10 ECNT.
MrsData  out  N  MRS read data.

Behaviour:
- States: RUN, FLUSH, HANDLER, RETURN.
- Reset (reset=0, asynchronous):
  - state=RUN; ELR, ESR, ECNT and the flush counter are cleared to 0.
  - All pulse outputs are 0; ExtIRQ_dec=0.
- ExtIRQ_dec = ExtIRQ_in & (state==RUN). Masked in FLUSH, HANDLER and RETURN.
- RUN, Exc_D=1 at a clock edge:
  - ELR<=PC_D.
  - ESR<={N-4 zeros, EStatus_D}.
  - ECNT<=ECNT+1, saturating at all-ones.
  - Counter<=FLUSH_CYCLES-1; next state FLUSH.
  - If EStatus_D==0001, IrqAck=1 during the first FLUSH cycle only.
- FLUSH:
  - Flush=1 every cycle; the counter decrements.
  - In the cycle the counter==0, VecTaken=1 as well; next state HANDLER.
  - Total time in FLUSH is exactly FLUSH_CYCLES cycles.
  - Exc_D and ERet_D are ignored.
- HANDLER:
  - ERet_D=1: next state RETURN.
  - Exc_D=1 (nested invalid opcode):
    - ELR is kept.
    - ESR[3:0]<=EStatus_D and ESR[8]<=1 (nested flag).
    - ECNT is incremented; next state FLUSH.
  - Exc_D has priority over ERet_D.
- RETURN:
  - Single cycle with Flush=1 and RetTaken=1; RetPC=ELR.
  - ESR[8]<=0; next state RUN.
  - Exc_D and ERet_D are ignored.
- RUN, ERet_D=1 with Exc_D=0: ignored (no flush, no register change).
- Simultaneous Exc_D and ERet_D in RUN: exception path only.
- Exc_D is meaningful only when EStatus_D is nonzero. Exc_D=1 with EStatus_D=0000 is still accepted and recorded verbatim in ESR.
- MrsData is combinational:
  - 00 -> ELR.
  - 01 -> ESR.
  - 10 -> ECNT zero-extended.
  - 11 -> 0.
- RetPC is combinational from ELR in all states.
- Reset mid-FLUSH or mid-HANDLER: immediate return to RUN with all registers cleared. No IrqAck is issued; the device keeps its request asserted.

Decomposition:
- Shared package (exc_pkg) holds:
  - The state enum.
  - EStatus codes: EST_NONE=0000, EST_IRQ=0001, EST_INVOP=0010.
  - MRS select codes.
  - The ESR nested-flag bit index (8).
- One natural sub-module: exc_regfile, holding ELR, ESR and ECNT with their write enables and the MRS read mux. The FSM and flush counter stay in exception_unit.

Test Plan:
- Invalid opcode: Exc_D=1, EStatus_D=0010, PC_D=0x40 in RUN.
  - Flush high for 3 cycles; VecTaken on the 3rd.
  - ELR=0x40, ESR=0x2, ECNT=1, IrqAck never asserted.
- IRQ: ExtIRQ_in=1 in RUN.
  - ExtIRQ_dec=1; drive Exc_D=1, EStatus_D=0001, PC_D=0x100.
  - IrqAck pulses 1 cycle after the accept edge; ExtIRQ_dec=0 while in FLUSH/HANDLER even with ExtIRQ_in held.
- ERET in HANDLER:
  - One cycle with Flush=1, RetTaken=1, RetPC=0x100.
  - Next cycle state RUN and ExtIRQ_dec follows ExtIRQ_in.
- Nested fault: in HANDLER, Exc_D=1, EStatus_D=0010, PC_D=0xE0.
  - ELR stays 0x100, ESR=0x102, re-vector after 3 flush cycles.
  - ERET then returns to 0x100 with ESR[8] cleared.
- Ignore cases:
  - ERet_D in RUN: no Flush, no RetTaken.
  - Exc_D during FLUSH: ELR and ECNT unchanged.
  - ECNT preset near saturation and driven with repeated exceptions: holds at 0xFFFF.
- Async reset asserted in mid-FLUSH: outputs go to 0 without waiting for a clock edge; state RUN after release; MrsData=0 for all selects.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and encodings for the LEGv8 exception unit and its register file.
package exc_pkg;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StHandler,
        StReturn
    } exc_state_e;

    localparam logic [3:0] EST_NONE  = 4'b0000;
    localparam logic [3:0] EST_IRQ   = 4'b0001;
    localparam logic [3:0] EST_INVOP = 4'b0010;

    localparam logic [1:0] MRS_ELR  = 2'b00;
    localparam logic [1:0] MRS_ESR  = 2'b01;
    localparam logic [1:0] MRS_ECNT = 2'b10;

    localparam int unsigned ESR_NEST_BIT = 8;

endpackage

// File: rtl/exc_regfile.sv
// Exception state registers ELR, ESR and the saturating ECNT, plus the MRS read mux.
module exc_regfile
    import exc_pkg::*;
#(
    parameter int unsigned N     = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         capture_i,
    input  logic         nest_i,
    input  logic         clr_nest_i,
    input  logic [3:0]   status_i,
    input  logic [N-1:0] pc_i,
    input  logic [1:0]   mrs_sel_i,
    output logic [N-1:0] elr_o,
    output logic [N-1:0] mrs_data_o
);

    logic [N-1:0]     elr_q, elr_d;
    logic [N-1:0]     esr_q, esr_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    always_comb begin
        elr_d  = elr_q;
        esr_d  = esr_q;
        ecnt_d = ecnt_q;
        if (capture_i) begin
            elr_d = pc_i;
            esr_d = {{(N-4){1'b0}}, status_i};
        end
        // A nested fault keeps ELR so ERET still returns to the original faulting PC.
        if (nest_i) begin
            esr_d[3:0]          = status_i;
            esr_d[ESR_NEST_BIT] = 1'b1;
        end
        if (clr_nest_i) begin
            esr_d[ESR_NEST_BIT] = 1'b0;
        end
        if ((capture_i || nest_i) && (ecnt_q != '1)) begin
            ecnt_d = ecnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            elr_q  <= '0;
            esr_q  <= '0;
            ecnt_q <= '0;
        end else begin
            elr_q  <= elr_d;
            esr_q  <= esr_d;
            ecnt_q <= ecnt_d;
        end
    end

    always_comb begin
        mrs_data_o = '0;
        unique case (mrs_sel_i)
            MRS_ELR:  mrs_data_o = elr_q;
            MRS_ESR:  mrs_data_o = esr_q;
            MRS_ECNT: mrs_data_o = N'(ecnt_q);
            default:  mrs_data_o = '0;
        endcase
    end

    assign elr_o = elr_q;

endmodule

// File: rtl/exception_unit.sv
// Exception sequencer beside decode: flush, vector, ERET return and IRQ gating.
module exception_unit
    import exc_pkg::*;
#(
    parameter int unsigned  N            = 64,
    parameter logic [N-1:0] VECTOR       = N'(64'h00000000000000D8),
    parameter int unsigned  FLUSH_CYCLES = 3,
    parameter int unsigned  CNT_W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Exc_D,
    input  logic [3:0]   EStatus_D,
    input  logic         ERet_D,
    input  logic [N-1:0] PC_D,
    input  logic         ExtIRQ_in,
    output logic         IrqAck,
    output logic         ExtIRQ_dec,
    output logic         Flush,
    output logic         VecTaken,
    output logic         RetTaken,
    output logic [N-1:0] RetPC,
    input  logic [1:0]   MrsSel,
    output logic [N-1:0] MrsData
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
        $error("FLUSH_CYCLES must lie in 1..15");
    end
    if (VECTOR[1:0] != 2'b00) begin : g_bad_vector
        $error("VECTOR must be word aligned");
    end

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    exc_state_e state_q;
    logic [3:0] cnt_q;
    logic       irq_ack_q;
    logic       accept_run;
    logic       accept_nest;

    assign accept_run  = (state_q == StRun) && Exc_D;
    assign accept_nest = (state_q == StHandler) && Exc_D;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            irq_ack_q <= 1'b0;
        end else begin
            irq_ack_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (Exc_D) begin
                        state_q   <= StFlush;
                        cnt_q     <= FlushLoad;
                        irq_ack_q <= (EStatus_D == EST_IRQ);
                    end
                end
                StFlush: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StHandler;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StHandler: begin
                    if (Exc_D) begin
                        state_q <= StFlush;
                        cnt_q   <= FlushLoad;
                    end else if (ERet_D) begin
                        state_q <= StReturn;
                    end
                end
                StReturn: state_q <= StRun;
                default:  state_q <= StRun;
            endcase
        end
    end

    assign Flush    = (state_q == StFlush) || (state_q == StReturn);
    assign VecTaken = (state_q == StFlush) && (cnt_q == 4'd0);
    assign RetTaken = (state_q == StReturn);
    assign IrqAck   = irq_ack_q;
    // Reset gates the IRQ too: state reads RUN while reset is held low.
    assign ExtIRQ_dec = ExtIRQ_in && reset && (state_q == StRun);

    exc_regfile #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_regfile (
        .clk_i      (clk),
        .rst_ni     (reset),
        .capture_i  (accept_run),
        .nest_i     (accept_nest),
        .clr_nest_i (RetTaken),
        .status_i   (EStatus_D),
        .pc_i       (PC_D),
        .mrs_sel_i  (MrsSel),
        .elr_o      (RetPC),
        .mrs_data_o (MrsData)
    );

endmodule
